// File: rtl/param_register_file_pkg.sv
// Shared definitions for the parametrised register file: sweep FSM state
// encoding and the default geometry used by the CPU datapath.
package param_register_file_pkg;

    typedef enum logic {
        RF_ST_CLEAR = 1'b0,
        RF_ST_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W_DEFAULT = 16;
    localparam int RF_ADDR_W_DEFAULT = 2;

endpackage

// File: rtl/param_register_file_clear_seq.sv
// Reset clear sequencer: after reset, zeroes one entry per cycle and raises
// ready once the final entry has been cleared.
module rf_clear_seq
    import param_register_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              ready_o
);

    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // State and sweep index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_ST_CLEAR;
            idx_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: advance through every entry, then settle in RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_ST_CLEAR: begin
                idx_d = idx_q + IDX_ONE;
                if (idx_q == IDX_LAST) begin
                    state_d = RF_ST_RUN;
                end else begin
                    state_d = RF_ST_CLEAR;
                end
            end
            RF_ST_RUN: begin
                state_d = RF_ST_RUN;
            end
            default: begin
                state_d = RF_ST_CLEAR;
                idx_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Outputs: the array is left untouched on the reset edge itself.
    always_comb begin
        clr_we_o   = (state_q == RF_ST_CLEAR) && !rst_i;
        clr_addr_o = idx_q;
        ready_o    = (state_q == RF_ST_RUN);
    end

endmodule

// File: rtl/param_register_file.sv
// Multi-port register file with synchronous write-first reads, a post-reset
// clear sweep gating writes, and an optional hardwired-zero entry 0.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEFAULT,
    parameter int ADDR_W   = RF_ADDR_W_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               waddr,
    input  logic [DATA_W-1:0]               wdata,
    input  logic [NUM_RD*ADDR_W-1:0]        raddr,
    output logic signed [NUM_RD*DATA_W-1:0] rdata,
    output logic                            ready,
    output logic                            wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              ready_s;
    logic              wr_acc_s;
    logic              wr_drop_q;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_we_o   (clr_we_s),
        .clr_addr_o (clr_addr_s),
        .ready_o    (ready_s)
    );

    // A user write lands only in RUN and never on a hardwired-zero entry.
    always_comb begin
        if (rst || !ready_s || !we) begin
            wr_acc_s = 1'b0;
        end else if ((ZERO_REG != 0) && (waddr == {ADDR_W{1'b0}})) begin
            wr_acc_s = 1'b0;
        end else begin
            wr_acc_s = 1'b1;
        end
    end

    // Storage write mux: the sweep owns the port until ready.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[clr_addr_s] <= {DATA_W{1'b0}};
        end else if (wr_acc_s) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Flag writes attempted while the sweep is still running.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= we && !ready_s;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] ra_s;
            logic [DATA_W-1:0] rd_q;

            assign ra_s = raddr[p*ADDR_W +: ADDR_W];

            // Registered read with write-first bypass; zeros until ready.
            always_ff @(posedge clk) begin
                if (rst || !ready_s) begin
                    rd_q <= {DATA_W{1'b0}};
                end else if ((ZERO_REG != 0) && (ra_s == {ADDR_W{1'b0}})) begin
                    rd_q <= {DATA_W{1'b0}};
                end else if (wr_acc_s && (waddr == ra_s)) begin
                    rd_q <= wdata;
                end else begin
                    rd_q <= mem_q[ra_s];
                end
            end

            assign rdata[p*DATA_W +: DATA_W] = rd_q;
        end
    endgenerate

    assign ready   = ready_s;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench: default 16x4x2 instance against an array-based model
// plus directed vectors; a second ZERO_REG=1, NUM_RD=3 instance for entry 0.
module tb_param_register_file;

    logic               clk = 1'b0;
    logic               rst, we;
    logic [1:0]         waddr;
    logic [15:0]        wdata;
    logic [3:0]         raddr;
    logic signed [31:0] rdata;
    logic               ready, wr_drop;

    logic               rst_b, we_b;
    logic [1:0]         waddr_b;
    logic [15:0]        wdata_b;
    logic [5:0]         raddr_b;
    logic signed [47:0] rdata_b;
    logic               ready_b, wr_drop_b;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model for the default instance
    logic [15:0] m_mem [4];
    logic [15:0] m_rd  [2];
    int          m_left;
    logic        m_drop;

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic [1:0]  ra0;
        logic [1:0]  ra1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        edrop;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    param_register_file #(.DATA_W(16), .ADDR_W(2), .NUM_RD(2), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .ready(ready), .wr_drop(wr_drop)
    );

    param_register_file #(.DATA_W(16), .ADDR_W(2), .NUM_RD(3), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .raddr(raddr_b), .rdata(rdata_b), .ready(ready_b), .wr_drop(wr_drop_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [1:0] wa,
                         input logic [15:0] wd, input logic [1:0] ra0, input logic [1:0] ra1);
        logic [1:0] ra;
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd; raddr = {ra1, ra0};
        @(posedge clk);
        if (r) begin
            m_left = 4; m_rd[0] = 16'h0000; m_rd[1] = 16'h0000; m_drop = 1'b0;
        end else if (m_left > 0) begin
            m_mem[4 - m_left] = 16'h0000;
            m_left--;
            m_rd[0] = 16'h0000; m_rd[1] = 16'h0000;
            m_drop = w;
        end else begin
            m_drop = 1'b0;
            for (int p = 0; p < 2; p++) begin
                ra = (p == 0) ? ra0 : ra1;
                m_rd[p] = (w && wa == ra) ? wd : m_mem[ra];
            end
            if (w) m_mem[wa] = wd;
        end
        #1;
        check("model_ready", 64'(ready), 64'(m_left == 0));
        check("model_rd0", 64'(rdata[15:0]), 64'(m_rd[0]));
        check("model_rd1", 64'(rdata[31:16]), 64'(m_rd[1]));
        check("model_drop", 64'(wr_drop), 64'(m_drop));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
    endtask

    // counts idle cycles until ready, bounded
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            cycle(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
            n++;
        end
    endtask

    task automatic cycle_b(input logic r, input logic w, input logic [1:0] wa,
                           input logic [15:0] wd, input logic [5:0] ra);
        @(negedge clk);
        rst_b = r; we_b = w; waddr_b = wa; wdata_b = wd; raddr_b = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 16'h0000; raddr = 4'd0;
        rst_b = 1'b1; we_b = 1'b0; waddr_b = 2'd0; wdata_b = 16'h0000; raddr_b = 6'd0;
        for (int i = 0; i < 4; i++) m_mem[i] = 16'h0000;
        m_left = 4; m_drop = 1'b0; m_rd[0] = 16'h0000; m_rd[1] = 16'h0000;

        vecs[0] = '{1'b1, 2'd2, 16'h8001, 2'd0, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 16'h0000, 2'd2, 2'd2, 16'h8001, 16'h8001, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 16'h1234, 2'd3, 2'd3, 16'h1234, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 16'h0000, 2'd3, 2'd2, 16'h1234, 16'h8001, 1'b0};
        vecs[4] = '{1'b1, 2'd1, 16'h00FF, 2'd1, 2'd0, 16'h00FF, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 16'hAAAA, 2'd1, 2'd1, 16'hAAAA, 16'hAAAA, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h0000, 16'h1234, 1'b0};

        // ZERO_REG=1, NUM_RD=3 instance (default instance held in reset)
        cycle_b(1'b1, 1'b0, 2'd0, 16'h0000, 6'd0);
        check("b_reset_ready", 64'(ready_b), 64'd0);
        for (int i = 0; i < 4; i++) cycle_b(1'b0, 1'b0, 2'd0, 16'h0000, 6'd0);
        check("b_sweep_ready", 64'(ready_b), 64'd1);
        cycle_b(1'b0, 1'b1, 2'd0, 16'h7FFF, 6'd0);
        check("b_r0_nobypass", 64'(rdata_b), 64'd0);
        check("b_r0_nodrop", 64'(wr_drop_b), 64'd0);
        cycle_b(1'b0, 1'b0, 2'd0, 16'h0000, 6'd0);
        check("b_r0_read", 64'(rdata_b), 64'd0);
        check("b_r0_nodrop2", 64'(wr_drop_b), 64'd0);
        cycle_b(1'b0, 1'b1, 2'd1, 16'h5555, {2'd1, 2'd0, 2'd1});
        check("b_r1_bypass", 64'(rdata_b), {16'd0, 16'h5555, 16'h0000, 16'h5555});

        // reset sweep on the default instance
        cycle(1'b1, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        wait_ready(n);
        check("first_sweep_len", 64'(n), 64'd4);

        // directed vectors: latency, bypass, overwrite
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
            check($sformatf("vec%0d_rd0", i), 64'(rdata[15:0]), 64'(vecs[i].e0));
            check($sformatf("vec%0d_rd1", i), 64'(rdata[31:16]), 64'(vecs[i].e1));
            check($sformatf("vec%0d_drop", i), 64'(wr_drop), 64'(vecs[i].edrop));
            if (i == 1) check("signed_rd0", 64'(int'($signed(rdata[15:0]))), 64'(-32767));
        end

        // preload nonzero, then reset sweep clears everything
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'(i), 16'hA5A0 + 16'(i), 2'd0, 2'd0);
        cycle(1'b1, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
        wait_ready(n);
        check("sweep_len", 64'(n), 64'd4);
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b0, 2'd0, 16'h0000, 2'(a), 2'(a));
            check($sformatf("cleared_r%0d", a), 64'(rdata), 64'd0);
        end

        // write during sweep is dropped
        cycle(1'b1, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
        idle_cycles(1);
        cycle(1'b0, 1'b1, 2'd1, 16'hBEEF, 2'd1, 2'd1);
        check("sweep_wr_drop", 64'(wr_drop), 64'd1);
        wait_ready(n);
        cycle(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd1);
        check("sweep_wr_r1", 64'(rdata), 64'd0);

        // reset mid-sweep restarts from index 0
        cycle(1'b1, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
        idle_cycles(2);
        cycle(1'b1, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);
        wait_ready(n);
        check("midsweep_len", 64'(n), 64'd4);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom), 16'($urandom),
                  2'($urandom), 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
